// File: rtl/output_fifo_buffer.sv
// DEPTH-entry register FIFO on a valid/ready link with registered in_ready and out_valid.
// Define OUTPUT_FIFO_LEVEL_EN to expose the occupancy count on port level.
module output_fifo_buffer #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned LEVEL_WIDTH = $clog2(DEPTH) + 1
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready
`ifdef OUTPUT_FIFO_LEVEL_EN
  ,
  output logic [LEVEL_WIDTH-1:0] level
`endif
);

  localparam int unsigned PTR_WIDTH = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0]  mem [DEPTH];
  logic [PTR_WIDTH-1:0]   wr_ptr;
  logic [PTR_WIDTH-1:0]   rd_ptr;
  logic [LEVEL_WIDTH-1:0] count;
  logic [LEVEL_WIDTH-1:0] count_nxt;
  logic                   wr_fire;
  logic                   rd_fire;

  // Handshakes and next occupancy; flags are derived from count_nxt so they stay registered.
  always_comb begin
    wr_fire   = in_valid & in_ready;
    rd_fire   = out_valid & out_ready;
    count_nxt = count;
    if (wr_fire && !rd_fire) begin
      count_nxt = count + LEVEL_WIDTH'(1);
    end else if (!wr_fire && rd_fire) begin
      count_nxt = count - LEVEL_WIDTH'(1);
    end
  end

  // Control state: pointers, occupancy and both link flags.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      out_valid <= 1'b0;
      in_ready  <= 1'b0;
    end else begin
      if (wr_fire) begin
        wr_ptr <= wr_ptr + PTR_WIDTH'(1);
      end
      if (rd_fire) begin
        rd_ptr <= rd_ptr + PTR_WIDTH'(1);
      end
      count     <= count_nxt;
      out_valid <= (count_nxt != '0);
      in_ready  <= (count_nxt != LEVEL_WIDTH'(DEPTH));
    end
  end

  // Storage is deliberately left unreset; only written on an accepted beat.
  always_ff @(posedge aclk) begin
    if (wr_fire) begin
      mem[wr_ptr] <= in_data;
    end
  end

  assign out_data = mem[rd_ptr];

`ifdef OUTPUT_FIFO_LEVEL_EN
  assign level = count;
`endif

endmodule

// File: tb/tb_output_fifo_buffer.sv
// Directed and throttled-random bench for output_fifo_buffer (DEPTH 4 main instance, DEPTH 2/16 for random).
module tb_output_fifo_buffer;

  localparam int unsigned N_RAND  = 10000;
  localparam int unsigned LIMIT   = 60000;

  logic        aclk;
  logic        aresetn;
  logic [31:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic [2:0]  level;
  logic [1:0]        r_in_valid;
  logic [1:0]        r_in_ready;
  logic [1:0][31:0]  r_in_data;
  logic [1:0]        r_out_valid;
  logic [1:0]        r_out_ready;
  logic [1:0][31:0]  r_out_data;
  logic [1:0]  lvl2;
  logic [4:0]  lvl16;

  int n_checks;
  int n_fail;

  output_fifo_buffer #(.DATA_WIDTH(32), .DEPTH(4)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready)
`ifdef OUTPUT_FIFO_LEVEL_EN
    , .level(level)
`endif
  );

  output_fifo_buffer #(.DATA_WIDTH(32), .DEPTH(2)) dut2 (
    .aclk(aclk), .aresetn(aresetn),
    .in_data(r_in_data[0]), .in_valid(r_in_valid[0]), .in_ready(r_in_ready[0]),
    .out_data(r_out_data[0]), .out_valid(r_out_valid[0]), .out_ready(r_out_ready[0])
`ifdef OUTPUT_FIFO_LEVEL_EN
    , .level(lvl2)
`endif
  );

  output_fifo_buffer #(.DATA_WIDTH(32), .DEPTH(16)) dut16 (
    .aclk(aclk), .aresetn(aresetn),
    .in_data(r_in_data[1]), .in_valid(r_in_valid[1]), .in_ready(r_in_ready[1]),
    .out_data(r_out_data[1]), .out_valid(r_out_valid[1]), .out_ready(r_out_ready[1])
`ifdef OUTPUT_FIFO_LEVEL_EN
    , .level(lvl16)
`endif
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

`ifndef OUTPUT_FIFO_LEVEL_EN
  assign level = '0;
  assign lvl2  = '0;
  assign lvl16 = '0;
`endif

  task automatic step;
    @(posedge aclk);
    #1;
  endtask

  task automatic test_reset;
    aresetn     = 1'b0;
    in_valid    = 1'b0;
    in_data     = '0;
    out_ready   = 1'b0;
    r_in_valid  = '0;
    r_in_data   = '0;
    r_out_ready = '0;
    step();
    step();
    n_checks++;
    if (in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_in_ready: got %b expected 0", in_ready);
    end
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_out_valid: got %b expected 0", out_valid);
    end
    aresetn = 1'b1;
    step();
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL release_flags: got in_ready=%b out_valid=%b expected 1/0", in_ready, out_valid);
    end
`ifdef OUTPUT_FIFO_LEVEL_EN
    n_checks++;
    if (level !== 3'd0) begin
      n_fail++;
      $display("FAIL release_level: got %0d expected 0", level);
    end
`endif
  endtask

  task automatic test_single_write;
    in_data  = 32'hA5A5_A5A5;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== 32'hA5A5_A5A5) begin
      n_fail++;
      $display("FAIL single_write: got valid=%b data=%h expected 1/a5a5a5a5", out_valid, out_data);
    end
`ifdef OUTPUT_FIFO_LEVEL_EN
    n_checks++;
    if (level !== 3'd1) begin
      n_fail++;
      $display("FAIL single_level: got %0d expected 1", level);
    end
`endif
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL single_drain: got valid=%b ready=%b expected 0/1", out_valid, in_ready);
    end
  endtask

  task automatic test_fill;
    for (int i = 1; i <= 4; i++) begin
      in_data  = 32'(i);
      in_valid = 1'b1;
      step();
    end
    n_checks++;
    if (in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL fill_full: got in_ready=%b expected 0", in_ready);
    end
    in_data = 32'd5;
    step();
    step();
    n_checks++;
    if (in_ready !== 1'b0 || out_data !== 32'd1) begin
      n_fail++;
      $display("FAIL fill_hold: got ready=%b head=%h expected 0/1", in_ready, out_data);
    end
`ifdef OUTPUT_FIFO_LEVEL_EN
    n_checks++;
    if (level !== 3'd4) begin
      n_fail++;
      $display("FAIL fill_level: got %0d expected 4", level);
    end
`endif
    in_valid = 1'b0;
  endtask

  task automatic test_drain;
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      n_checks++;
      if (out_valid !== 1'b1 || out_data !== 32'(i)) begin
        n_fail++;
        $display("FAIL drain_word%0d: got valid=%b data=%h expected 1/%h", i, out_valid, out_data, 32'(i));
      end
      step();
      if (i == 1) begin
        n_checks++;
        if (in_ready !== 1'b1) begin
          n_fail++;
          $display("FAIL drain_reopen: got in_ready=%b expected 1", in_ready);
        end
      end
    end
    out_ready = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL drain_empty: got valid=%b ready=%b expected 0/1", out_valid, in_ready);
    end
  endtask

  task automatic test_stream;
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      in_data  = 32'(i + 100);
      in_valid = 1'b1;
      step();
      n_checks++;
      if (out_valid !== 1'b1 || out_data !== 32'(i + 100) || in_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL stream_%0d: got valid=%b data=%h ready=%b expected 1/%h/1",
                 i, out_valid, out_data, in_ready, 32'(i + 100));
      end
`ifdef OUTPUT_FIFO_LEVEL_EN
      n_checks++;
      if (level !== 3'd1) begin
        n_fail++;
        $display("FAIL stream_level_%0d: got %0d expected 1", i, level);
      end
`endif
    end
    in_valid = 1'b0;
    step();
    out_ready = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL stream_end: got valid=%b expected 0", out_valid);
    end
  endtask

  task automatic test_random;
    logic [31:0] sb0[$];
    logic [31:0] sb1[$];
    int          sent [2];
    int          got  [2];
    bit          pend [2];
    bit          stall[2];
    logic [31:0] held [2];
    logic [31:0] exp_w;
    int          cyc;
    int          lv;
    bit          w;
    bit          r;
    for (int d = 0; d < 2; d++) begin
      sent[d] = 0; got[d] = 0; pend[d] = 1'b0; stall[d] = 1'b0; held[d] = '0;
    end
    cyc = 0;
    while ((got[0] < int'(N_RAND) || got[1] < int'(N_RAND)) && cyc < int'(LIMIT)) begin
      for (int d = 0; d < 2; d++) begin
        if (!pend[d]) begin
          if (sent[d] < int'(N_RAND) && $urandom_range(3) != 0) begin
            r_in_valid[d] = 1'b1;
            r_in_data[d]  = $urandom;
          end else begin
            r_in_valid[d] = 1'b0;
          end
        end
        r_out_ready[d] = ($urandom_range(3) != 0);
      end
      #1;
      for (int d = 0; d < 2; d++) begin
        w = r_in_valid[d] & r_in_ready[d];
        r = r_out_valid[d] & r_out_ready[d];
        if (r) begin
          exp_w = (d == 0) ? ((sb0.size() > 0) ? sb0.pop_front() : 32'hx)
                           : ((sb1.size() > 0) ? sb1.pop_front() : 32'hx);
          n_checks++;
          if (r_out_data[d] !== exp_w) begin
            n_fail++;
            $display("FAIL rand_data dut%0d word%0d: got %h expected %h", d, got[d], r_out_data[d], exp_w);
          end
          got[d]++;
        end
        if (w) begin
          if (d == 0) sb0.push_back(r_in_data[d]);
          else        sb1.push_back(r_in_data[d]);
          sent[d]++;
        end
        pend[d]  = r_in_valid[d] & ~w;
        stall[d] = r_out_valid[d] & ~r_out_ready[d];
        held[d]  = r_out_data[d];
      end
      step();
      cyc++;
      for (int d = 0; d < 2; d++) begin
        if (stall[d]) begin
          n_checks++;
          if (r_out_valid[d] !== 1'b1 || r_out_data[d] !== held[d]) begin
            n_fail++;
            $display("FAIL rand_stall dut%0d: got valid=%b data=%h expected 1/%h",
                     d, r_out_valid[d], r_out_data[d], held[d]);
          end
        end
`ifdef OUTPUT_FIFO_LEVEL_EN
        lv = (d == 0) ? int'(lvl2) : int'(lvl16);
        n_checks++;
        if (lv != ((d == 0) ? sb0.size() : sb1.size())) begin
          n_fail++;
          $display("FAIL rand_level dut%0d: got %0d expected %0d", d, lv, (d == 0) ? sb0.size() : sb1.size());
        end
`else
        lv = 0;
`endif
      end
    end
    r_in_valid  = '0;
    r_out_ready = '0;
    n_checks++;
    if (cyc >= int'(LIMIT)) begin
      n_fail++;
      $display("FAIL rand_timeout: got %0d/%0d words expected %0d each", got[0], got[1], N_RAND);
    end
  endtask

  task automatic test_reset_mid;
    for (int i = 0; i < 3; i++) begin
      in_data  = 32'hC0DE_0000 + 32'(i);
      in_valid = 1'b1;
      step();
    end
    in_valid = 1'b0;
    #2;
    aresetn = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_async: got valid=%b ready=%b expected 0/0", out_valid, in_ready);
    end
    step();
    aresetn = 1'b1;
    step();
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL midreset_empty: got valid=%b ready=%b expected 0/1", out_valid, in_ready);
    end
`ifdef OUTPUT_FIFO_LEVEL_EN
    n_checks++;
    if (level !== 3'd0) begin
      n_fail++;
      $display("FAIL midreset_level: got %0d expected 0", level);
    end
`endif
    in_data  = 32'h1234_5678;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== 32'h1234_5678) begin
      n_fail++;
      $display("FAIL midreset_fresh: got valid=%b data=%h expected 1/12345678", out_valid, out_data);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_single_write();
    test_fill();
    test_drain();
    test_stream();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
